// File: rtl/trs_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trs_loader_pkg - parser states, record codes and length decode for the TRS
// image loader; SYSTEM states exist only with LOADER_SYSTEM_TAPE_EN. Rev 1.0
// ----------------------------------------------------------------------------
package trs_loader_pkg;

  typedef enum logic [4:0] {
    ST_TYPE, ST_LEN, ST_ALO, ST_AHI, ST_DATA, ST_XLO, ST_XHI, ST_SKIP, ST_END, ST_ERR
`ifdef LOADER_SYSTEM_TAPE_EN
    , ST_SYNC, ST_NAME, ST_BTYPE, ST_BLEN, ST_BALO, ST_BAHI, ST_BDATA, ST_BCSUM,
    ST_ELO, ST_EHI
`endif
  } state_t;

  typedef enum logic [1:0] {K_LOAD, K_XFER, K_SKIP} kind_t;

  localparam logic [7:0] REC_LOAD  = 8'h01;
  localparam logic [7:0] REC_XFER  = 8'h02;
`ifdef LOADER_SYSTEM_TAPE_EN
  localparam logic [7:0] SYS_DATA  = 8'h3C;
  localparam logic [7:0] SYS_ENTRY = 8'h78;
  localparam logic [7:0] SYS_SYNC  = 8'hA5;
`endif

  // CMD load length counts the two address bytes; 0..2 wrap to 254..256 data bytes.
  function automatic logic [8:0] cmd_data_count(input logic [7:0] n);
    return (n < 8'd3) ? ({1'b0, n} + 9'd254) : ({1'b0, n} - 9'd2);
  endfunction

  function automatic logic [8:0] len256(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

endpackage
`default_nettype wire

// File: rtl/trs_loader_wrq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trs_loader_wrq - single-entry write holding register; wr held until ready.
// Rev 1.0
// ----------------------------------------------------------------------------
module trs_loader_wrq #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [7:0]        push_data,
  input  logic              ready,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (push) begin
      wr   <= 1'b1;
      addr <= push_addr;
      data <= push_data;
    end else if (wr && ready) begin
      wr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trs_image_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trs_image_loader - parses TRS-80 /CMD images (and SYSTEM tapes when
// LOADER_SYSTEM_TAPE_EN is defined) from hps_io into RAM byte writes. Rev 1.0
// ----------------------------------------------------------------------------
module trs_image_loader
  import trs_loader_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  CMD_INDEX = 8'd2,
  parameter logic [7:0]  SYS_INDEX = 8'd3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              loader_download,
  output logic              loader_wr,
  input  logic              loader_ready,
  output logic [ADDR_W-1:0] loader_addr,
  output logic [7:0]        loader_data,
  output logic [15:0]       execute_addr,
  output logic              execute_enable,
  output logic              load_error
);

  localparam logic [ADDR_W-1:0] BASE_OFS = ADDR_W'(BASE_ADDR);

  state_t      state, state_n, cur, init_state;
  kind_t       kind, kind_n;
  logic [8:0]  count, count_n;
  logic [15:0] rec_addr, rec_addr_n, exec_n;
  logic        xfer_seen, xfer_n, err_n, in_session, session_n, download_n, exec_en_n;
  logic        idx_sys_raw, idx_sys, idx_cmd, start, byte_ok, finish, end_ok;
  logic        push;
  logic [ADDR_W-1:0] push_addr;

  assign idx_sys_raw = (ioctl_index == SYS_INDEX);
  assign idx_cmd     = (ioctl_index == CMD_INDEX) && !idx_sys_raw;

`ifdef LOADER_SYSTEM_TAPE_EN
  logic [7:0] csum, csum_n;
  assign idx_sys    = idx_sys_raw;
  assign init_state = idx_sys ? ST_SYNC : ST_TYPE;
  assign end_ok     = (state == ST_TYPE) || (state == ST_END) || (state == ST_ERR) ||
                      (state == ST_SYNC) || (state == ST_BTYPE);
`else
  assign idx_sys    = 1'b0;
  assign init_state = ST_TYPE;
  assign end_ok     = (state == ST_TYPE) || (state == ST_END) || (state == ST_ERR);
`endif

  // Bytes strobed while a write is pending are dropped, never queued.
  assign start      = ioctl_download && (idx_cmd || idx_sys) && !in_session;
  assign byte_ok    = ioctl_download && (in_session || idx_cmd || idx_sys) &&
                      ioctl_wr && !loader_wr;
  assign finish     = in_session && !ioctl_download && !loader_wr;
  assign ioctl_wait = loader_wr;
  assign push_addr  = ADDR_W'(rec_addr) + BASE_OFS;

  always_comb begin
    state_n    = state;
    kind_n     = kind;
    count_n    = count;
    rec_addr_n = rec_addr;
    exec_n     = execute_addr;
    xfer_n     = xfer_seen;
    err_n      = load_error;
    session_n  = in_session;
    download_n = loader_download;
    exec_en_n  = 1'b0;
    push       = 1'b0;
    cur        = state;
`ifdef LOADER_SYSTEM_TAPE_EN
    csum_n     = csum;
`endif
    if (start) begin
      session_n = 1'b1;
      err_n     = 1'b0;
      xfer_n    = 1'b0;
      exec_n    = '0;
      cur       = init_state;
      state_n   = init_state;
    end
    if (byte_ok) begin
      download_n = 1'b1;
      case (cur)
        ST_TYPE: begin
          state_n = ST_LEN;
          if (ioctl_dout == REC_LOAD)      kind_n = K_LOAD;
          else if (ioctl_dout == REC_XFER) kind_n = K_XFER;
          else                             kind_n = K_SKIP;
        end
        ST_LEN: begin
          case (kind)
            K_LOAD: begin
              count_n = cmd_data_count(ioctl_dout);
              state_n = ST_ALO;
            end
            K_XFER:  state_n = ST_XLO;
            default: begin
              count_n = len256(ioctl_dout);
              state_n = ST_SKIP;
            end
          endcase
        end
        ST_ALO: begin
          rec_addr_n[7:0] = ioctl_dout;
          state_n         = ST_AHI;
        end
        ST_AHI: begin
          rec_addr_n[15:8] = ioctl_dout;
          state_n          = ST_DATA;
        end
        ST_DATA: begin
          push       = 1'b1;
          rec_addr_n = rec_addr + 16'd1;
          count_n    = count - 9'd1;
          if (count == 9'd1) state_n = ST_TYPE;
        end
        ST_XLO: begin
          exec_n[7:0] = ioctl_dout;
          state_n     = ST_XHI;
        end
        ST_XHI: begin
          exec_n[15:8] = ioctl_dout;
          xfer_n       = 1'b1;
          state_n      = ST_END;
        end
        ST_SKIP: begin
          count_n = count - 9'd1;
          if (count == 9'd1) state_n = ST_TYPE;
        end
`ifdef LOADER_SYSTEM_TAPE_EN
        ST_SYNC: begin
          if (ioctl_dout == SYS_SYNC) begin
            count_n = 9'd6;
            state_n = ST_NAME;
          end else if (ioctl_dout != 8'h00) begin
            err_n   = 1'b1;
            state_n = ST_ERR;
          end
        end
        ST_NAME: begin
          count_n = count - 9'd1;
          if (count == 9'd1) state_n = ST_BTYPE;
        end
        ST_BTYPE: begin
          if (ioctl_dout == SYS_DATA)       state_n = ST_BLEN;
          else if (ioctl_dout == SYS_ENTRY) state_n = ST_ELO;
          else begin
            err_n   = 1'b1;
            state_n = ST_ERR;
          end
        end
        ST_BLEN: begin
          count_n = len256(ioctl_dout);
          state_n = ST_BALO;
        end
        ST_BALO: begin
          rec_addr_n[7:0] = ioctl_dout;
          csum_n          = ioctl_dout;
          state_n         = ST_BAHI;
        end
        ST_BAHI: begin
          rec_addr_n[15:8] = ioctl_dout;
          csum_n           = csum + ioctl_dout;
          state_n          = ST_BDATA;
        end
        ST_BDATA: begin
          push       = 1'b1;
          csum_n     = csum + ioctl_dout;
          rec_addr_n = rec_addr + 16'd1;
          count_n    = count - 9'd1;
          if (count == 9'd1) state_n = ST_BCSUM;
        end
        ST_BCSUM: begin
          if (ioctl_dout != csum) begin
            err_n   = 1'b1;
            state_n = ST_ERR;
          end else begin
            state_n = ST_BTYPE;
          end
        end
        ST_ELO: begin
          exec_n[7:0] = ioctl_dout;
          state_n     = ST_EHI;
        end
        ST_EHI: begin
          exec_n[15:8] = ioctl_dout;
          xfer_n       = 1'b1;
          state_n      = ST_END;
        end
`endif
        default: ;
      endcase
    end
    // Session closes only once the last write has drained.
    if (finish) begin
      session_n  = 1'b0;
      download_n = 1'b0;
      state_n    = ST_TYPE;
      if (!end_ok) err_n = 1'b1;
      exec_en_n  = xfer_seen && !load_error && end_ok;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_TYPE;
      kind            <= K_LOAD;
      count           <= '0;
      rec_addr        <= '0;
      execute_addr    <= '0;
      xfer_seen       <= 1'b0;
      load_error      <= 1'b0;
      in_session      <= 1'b0;
      loader_download <= 1'b0;
      execute_enable  <= 1'b0;
`ifdef LOADER_SYSTEM_TAPE_EN
      csum            <= '0;
`endif
    end else begin
      state           <= state_n;
      kind            <= kind_n;
      count           <= count_n;
      rec_addr        <= rec_addr_n;
      execute_addr    <= exec_n;
      xfer_seen       <= xfer_n;
      load_error      <= err_n;
      in_session      <= session_n;
      loader_download <= download_n;
      execute_enable  <= exec_en_n;
`ifdef LOADER_SYSTEM_TAPE_EN
      csum            <= csum_n;
`endif
    end
  end

  trs_loader_wrq #(.ADDR_W(ADDR_W)) u_wrq (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_addr (push_addr),
    .push_data (ioctl_dout),
    .ready     (loader_ready),
    .wr        (loader_wr),
    .addr      (loader_addr),
    .data      (loader_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_trs_image_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_trs_image_loader - directed self-checking bench for trs_image_loader.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_trs_image_loader;

`ifdef LOADER_SYSTEM_TAPE_EN
  localparam int          TB_AW   = 17;
  localparam int unsigned TB_BASE = 32'h10000;
`else
  localparam int          TB_AW   = 16;
  localparam int unsigned TB_BASE = 0;
`endif

  logic             clock = 1'b0;
  logic             reset, ioctl_download, ioctl_wr, loader_ready;
  logic [7:0]       ioctl_index, ioctl_dout;
  logic             ioctl_wait, loader_download, loader_wr, execute_enable, load_error;
  logic [TB_AW-1:0] loader_addr;
  logic [7:0]       loader_data;
  logic [15:0]      execute_addr;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [TB_AW-1:0] wa[$];
  logic [7:0]       wd[$];

  trs_image_loader #(.ADDR_W(TB_AW), .BASE_ADDR(TB_BASE), .CMD_INDEX(8'd2), .SYS_INDEX(8'd3)) dut (
    .clock           (clock),
    .reset           (reset),
    .ioctl_download  (ioctl_download),
    .ioctl_index     (ioctl_index),
    .ioctl_wr        (ioctl_wr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_wait      (ioctl_wait),
    .loader_download (loader_download),
    .loader_wr       (loader_wr),
    .loader_ready    (loader_ready),
    .loader_addr     (loader_addr),
    .loader_data     (loader_data),
    .execute_addr    (execute_addr),
    .execute_enable  (execute_enable),
    .load_error      (load_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (loader_wr && loader_ready) begin
      wa.push_back(loader_addr);
      wd.push_back(loader_data);
    end
    if (execute_enable) pulses++;
  end

  function automatic logic [31:0] ea(input logic [15:0] a);
    return (32'(a) + TB_BASE) & ((32'd1 << TB_AW) - 32'd1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (ioctl_wait && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $error("FAIL wait_timeout: observed ioctl_wait=1 expected 0");
    end
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic begin_session(input logic [7:0] idx);
    wa.delete();
    wd.delete();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_session();
    ioctl_download = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; loader_ready = 1'b1;
    ioctl_index = 8'd0; ioctl_dout = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_ctrl", {ioctl_wait, loader_download, loader_wr, execute_enable, load_error}, 0);
    check("reset_addr", loader_addr, 0);
    check("reset_data", loader_data, 0);
    check("reset_exec", execute_addr, 0);

    // Basic load + transfer
    begin_session(8'd2);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h70);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h70);
    check("basic_dl_high", loader_download, 1);
    check("basic_nwr", wa.size(), 3);
    check("basic_a0", wa[0], ea(16'h7000)); check("basic_d0", wd[0], 8'hAA);
    check("basic_a1", wa[1], ea(16'h7001)); check("basic_d1", wd[1], 8'hBB);
    check("basic_a2", wa[2], ea(16'h7002)); check("basic_d2", wd[2], 8'hCC);
    check("basic_no_early_pulse", pulses, 0);
    end_session();
    check("basic_pulse", pulses, 1);
    check("basic_exec", execute_addr, 16'h7000);
    check("basic_dl_low", loader_download, 0);
    check("basic_err", load_error, 0);

    // n=2 block: 256 data bytes
    begin_session(8'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h80);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    end_session();
    check("len256_nwr", wa.size(), 256);
    check("len256_first", wa[0], ea(16'h8000));
    check("len256_last_a", wa[255], ea(16'h80FF));
    check("len256_last_d", wd[255], 8'hFF);
    check("len256_err", load_error, 0);
    check("len256_nopulse", pulses, 1);

    // Back-pressure: ready low for 5 cycles, a stray strobe during wait is dropped
    loader_ready = 1'b0;
    begin_session(8'd2);
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h34); send_byte(8'h12);
    ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_wr", loader_wr, 1);
      check("hold_wait", ioctl_wait, 1);
      check("hold_addr", loader_addr, ea(16'h1234));
      check("hold_data", loader_data, 8'h5A);
      ioctl_dout = 8'h01;
      ioctl_wr   = (i == 2);
      tick();
      ioctl_wr = 1'b0;
    end
    loader_ready = 1'b1;
    check("hold_wr_6th", loader_wr, 1);
    tick();
    check("hold_wr_drop", loader_wr, 0);
    check("hold_wait_drop", ioctl_wait, 0);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
    end_session();
    check("hold_nwr", wa.size(), 1);
    check("hold_d0", wd[0], 8'h5A);
    check("hold_pulse", pulses, 2);
    check("hold_exec", execute_addr, 16'h1234);

    // Comment record skipped before a load
    begin_session(8'd2);
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h90);
    send_byte(8'h11); send_byte(8'h22);
    end_session();
    check("skip_nwr", wa.size(), 2);
    check("skip_a0", wa[0], ea(16'h9000)); check("skip_d0", wd[0], 8'h11);
    check("skip_a1", wa[1], ea(16'h9001)); check("skip_d1", wd[1], 8'h22);
    check("skip_err", load_error, 0);

`ifndef LOADER_SYSTEM_TAPE_EN
    // SYS_INDEX is foreign without the tape option
    begin_session(8'd3);
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'hA0);
    send_byte(8'h55); send_byte(8'h66);
    check("foreign_dl", loader_download, 0);
    end_session();
    check("foreign_nwr", wa.size(), 0);
    check("foreign_pulse", pulses, 2);
`else
    // SYSTEM block wrapping 0xFFFF -> 0x0000, then entry record
    begin_session(8'd3);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hA5);
    send_byte(8'h50); send_byte(8'h52); send_byte(8'h4F);
    send_byte(8'h47); send_byte(8'h20); send_byte(8'h20);
    send_byte(8'h3C); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h31);
    send_byte(8'h78); send_byte(8'h00); send_byte(8'h70);
    end_session();
    check("sys_nwr", wa.size(), 2);
    check("sys_a0", wa[0], 32'h1FFFF); check("sys_d0", wd[0], 8'h11);
    check("sys_a1", wa[1], 32'h10000); check("sys_d1", wd[1], 8'h22);
    check("sys_err", load_error, 0);
    check("sys_pulse", pulses, 3);
    check("sys_exec", execute_addr, 16'h7000);

    begin_session(8'd3);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(8'h41);
    send_byte(8'h3C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h50);
    send_byte(8'h77); send_byte(8'h00);
    end_session();
    check("sys_bad_csum_err", load_error, 1);
    check("sys_bad_csum_pulse", pulses, 3);
`endif

    // Truncated inside DATA
    begin_session(8'd2);
    check("trunc_err_cleared", load_error, 0);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h70); send_byte(8'hAA);
    end_session();
    check("trunc_err", load_error, 1);
`ifdef LOADER_SYSTEM_TAPE_EN
    check("trunc_pulse", pulses, 3);
`else
    check("trunc_pulse", pulses, 2);
`endif

    // Reset mid-session abandons the pending write
    loader_ready = 1'b0;
    begin_session(8'd2);
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'hB0);
    ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("rst_pending_wr", loader_wr, 1);
    reset = 1'b1;
    tick();
    check("rst_wr", loader_wr, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_dl", loader_download, 0);
    check("rst_addr", loader_addr, 0);
    check("rst_err", load_error, 0);
    reset = 1'b0; ioctl_download = 1'b0; loader_ready = 1'b1;
    repeat (4) tick();
    check("rst_nwr", wa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
